// File: rtl/ricevitore_seriale_if.sv
// Signal bundle between the serial receiver and its neighbours: the serial
// line coming in and the byte/write-enable pair feeding the 8-bit register.
interface ricevitore_seriale_if;
    logic       rx;
    logic [7:0] data;
    logic       we;
    logic       busy;
    logic       frame_err;

    // Side that drives the serial line and consumes the received bytes.
    modport master (
        output rx,
        input  data,
        input  we,
        input  busy,
        input  frame_err
    );

    // The receiver itself.
    modport slave (
        input  rx,
        output data,
        output we,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/ricevitore_seriale.sv
// UART-style serial receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// A valid frame updates data and pulses we for one cycle. A low stop bit
// pulses frame_err instead, and the receiver then waits for the line to go
// high again so that a break never looks like a new start bit.
module ricevitore_seriale #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    ricevitore_seriale_if.slave   bus
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic             rx_meta_r;
    logic             rx_sync_r;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic [7:0]       data_r;
    logic [7:0]       data_s;
    logic             we_r;
    logic             we_s;
    logic             ferr_r;
    logic             ferr_s;
    logic             busy_r;

    // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state logic: bit timing, sampling decisions and output pulses.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + CNT_W'(1);
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        data_s    = data_r;
        we_s      = 1'b0;
        ferr_s    = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (!rx_sync_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                // Mid start bit: a line that is already high again was a glitch.
                if (cnt_r == HALF_LAST) begin
                    cnt_s = '0;
                    if (rx_sync_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    state_s = START;
                end
            end

            DATA: begin
                // Shift right so the first (LSB) bit ends up in bit 0.
                if (cnt_r == BIT_LAST) begin
                    cnt_s     = '0;
                    shift_s   = {rx_sync_r, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end

            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = '0;
                    if (rx_sync_r) begin
                        data_s  = shift_r;
                        we_s    = 1'b1;
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAIT_HIGH;
                    end
                end else begin
                    state_s = STOP;
                end
            end

            WAIT_HIGH: begin
                cnt_s = '0;
                if (rx_sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset discards any partial frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            data_r    <= 8'h00;
            we_r      <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            data_r    <= data_s;
            we_r      <= we_s;
            ferr_r    <= ferr_s;
            busy_r    <= (state_s != IDLE);
        end
    end

    assign bus.data      = data_r;
    assign bus.we        = we_r;
    assign bus.frame_err = ferr_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ricevitore_seriale.sv
// Bench for ricevitore_seriale: the stimulus process drives serial frames and
// pushes the expected response (kind, byte, edge number) into a scoreboard;
// a monitor on the falling edge pops and compares whenever we/frame_err fires.
module tb_ricevitore_seriale;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;

    typedef struct packed {
        logic        is_err;
        logic [7:0]  byte_v;
        logic [31:0] at_edge;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   expect_idle = 1'b0;
    logic [7:0] model_data = 8'h00;
    exp_t sb_q[$];

    ricevitore_seriale_if bus_if();

    ricevitore_seriale #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One full frame; expected response is queued before the line moves.
    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        exp_t e;
        int   k;
        k = cyc + 1;
        e.is_err  = ~stop_b;
        e.byte_v  = b;
        e.at_edge = 32'(k + 2 + HALF + 9 * CPB);
        sb_q.push_back(e);
        bus_if.rx = 1'b0;
        wait_cyc(CPB);
        check("busy_in_frame", int'(bus_if.busy), 1);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            wait_cyc(CPB);
        end
        bus_if.rx = stop_b;
        wait_cyc(CPB);
    endtask

    // Frame cut by a one-cycle reset during data bit 4; nothing may come out.
    task automatic send_aborted(input logic [7:0] b);
        bus_if.rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            if (i == 4) begin
                wait_cyc(2);
                reset = 1'b1;
                wait_cyc(1);
                reset = 1'b0;
                check("abort_data", int'(bus_if.data), 0);
                check("abort_we", int'(bus_if.we), 0);
                check("abort_busy", int'(bus_if.busy), 0);
                expect_idle = 1'b1;
                wait_cyc(CPB - 3);
            end else begin
                wait_cyc(CPB);
            end
        end
        bus_if.rx = 1'b1;
        wait_cyc(CPB);
        expect_idle = 1'b0;
    endtask

    // Monitor: compares every output pulse against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (rst_q) begin
            model_data = 8'h00;
            check("rst_data", int'(bus_if.data), 0);
            check("rst_we", int'(bus_if.we), 0);
            check("rst_busy", int'(bus_if.busy), 0);
            check("rst_ferr", int'(bus_if.frame_err), 0);
        end else begin
            if (bus_if.we || bus_if.frame_err) begin
                check("we_ferr_excl", int'(bus_if.we && bus_if.frame_err), 0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got we=%0d frame_err=%0d expected none (edge %0d)",
                             bus_if.we, bus_if.frame_err, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_kind_ferr", int'(bus_if.frame_err), int'(e.is_err));
                    check("pulse_edge", cyc, int'(e.at_edge));
                    check("busy_at_pulse", int'(bus_if.busy), int'(e.is_err));
                    if (!e.is_err) begin
                        check("pulse_data", int'(bus_if.data), int'(e.byte_v));
                        model_data = e.byte_v;
                    end
                end
            end
            check("data_hold", int'(bus_if.data), int'(model_data));
            if (expect_idle)
                check("idle_busy", int'(bus_if.busy), 0);
        end
    end

    initial begin
        logic [7:0] rb;
        logic       rstop;
        bus_if.rx = 1'b1;
        reset = 1'b1;

        // Reset from time 0 with an idle line, then 50 quiet cycles.
        wait_cyc(5);
        check("reset_data", int'(bus_if.data), 0);
        check("reset_busy", int'(bus_if.busy), 0);
        reset = 1'b0;
        expect_idle = 1'b1;
        wait_cyc(50);
        expect_idle = 1'b0;

        // Plain frame.
        send_frame(8'hA5, 1'b1);
        wait_cyc(2);

        // Framing error with the line held low, then recovery.
        send_frame(8'h5A, 1'b0);
        wait_cyc(16);
        check("break_busy", int'(bus_if.busy), 1);
        bus_if.rx = 1'b1;
        wait_cyc(6);
        check("after_break_busy", int'(bus_if.busy), 0);
        send_frame(8'h0F, 1'b1);
        wait_cyc(2);

        // Back-to-back frames with minimum stop bit.
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_cyc(2);

        // One-cycle glitch rejected at mid start bit.
        bus_if.rx = 1'b0;
        wait_cyc(1);
        bus_if.rx = 1'b1;
        wait_cyc(HALF + 3);
        check("glitch_busy", int'(bus_if.busy), 0);
        expect_idle = 1'b1;
        wait_cyc(10);
        expect_idle = 1'b0;

        // Reset in the middle of a frame, then a clean frame.
        send_aborted(8'hF3);
        wait_cyc(2);
        send_frame(8'h81, 1'b1);

        // Randomised frames, gaps and occasional bad stop bits.
        for (int n = 0; n < 12; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 4) != 0);
            bus_if.rx = 1'b1;
            wait_cyc($urandom_range(0, 6));
            send_frame(rb, rstop);
            if (!rstop) begin
                bus_if.rx = 1'b1;
                wait_cyc(4);
            end
        end

        bus_if.rx = 1'b1;
        wait_cyc(60);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ricevitore_seriale.md
Name: ricevitore_seriale

Overview:
- Serial-to-parallel receiver that sits directly upstream of the 8-bit write-enabled register.
- Samples an asynchronous, UART-style serial line (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) and assembles each byte.
- On a valid frame, presents the byte on data and pulses we for one cycle; data/we connect straight to the register's in/we.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be even and >= 4; HALF = CLKS_PER_BIT/2.

Ports:
- clock  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- rx  input  1  serial line, asynchronous to clock, idle = 1
- data  output  8  last correctly received byte; feeds register in
- we  output  1  one-cycle pulse when data is updated; feeds register we
- busy  output  1  high while a frame is in progress (any state except IDLE)
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- While reset=1 at a rising edge:
  - data=8'h00, we=0, busy=0, frame_err=0
  - synchroniser flops set to 1; FSM to IDLE; bit counter and cycle counter cleared.
  - This applies mid-frame too: the partial byte is discarded.
- Input sync: rx passes through a 2-flop synchroniser (rx_s). The FSM uses only rx_s, so it lags rx by 2 edges.
- All outputs are registered. we and frame_err are never high in the same cycle and never high for more than 1 cycle.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s=0 -> START, cycle counter=0.
  - Otherwise stay in IDLE.
- START:
  - After HALF cycles (mid start bit), resample rx_s.
  - rx_s=1 -> glitch/false start -> IDLE, no output.
  - rx_s=0 -> DATA, cycle counter=0, bit index=0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register: shift right, new bit enters bit 7, so the byte ends LSB-first correct.
  - After the sample with bit index=7 -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1: data <= shift register, we=1 for the next cycle, go to IDLE.
  - rx_s=0: frame_err=1 for the next cycle, data unchanged, we stays 0, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay while rx_s=0, so a break/stuck-low line never restarts a frame.
  - rx_s=1 -> IDLE.
- Cycle-level timing, with rx falling (start bit) between edges k-1 and k:
  - FSM leaves IDLE at edge k+2.
  - Start mid-sample at edge k+2+HALF.
  - Data bit i (i=0..7) sampled at edge k+2+HALF+(i+1)*CLKS_PER_BIT.
  - Stop sample at edge k+2+HALF+9*CLKS_PER_BIT.
  - we (or frame_err) is high from that edge to the next.
  - Example, CLKS_PER_BIT=4: stop sample at edge k+40.
- Back-to-back frames:
  - IDLE is re-entered right after the stop sample.
  - A start bit that begins immediately after a 1-bit-long stop bit must be received correctly.
- busy:
  - Goes high the edge FSM leaves IDLE.
  - Goes low the edge it returns to IDLE; WAIT_HIGH counts as busy.
- data is held between frames; only a valid stop bit updates it.

Test Plan:
- Send 0xA5 (CLKS_PER_BIT=4), rx falls before edge k -> data=8'hA5 and we=1 exactly in the cycle after edge k+40; busy=0 afterwards.
- Send 0x3C then 0xC3 back-to-back, stop bits exactly 4 cycles -> two single-cycle we pulses 40 cycles apart; data=8'h3C then 8'hC3; frame_err never 1.
- rx low for 1 cycle only, then high -> START rejects at mid-sample; no we, no frame_err; busy returns to 0 within HALF+3 cycles.
- Send 0x5A with stop bit 0, rx held low 20 cycles, then high -> frame_err one-cycle pulse; we=0; data keeps previous 8'hA5; no new frame starts until rx high; then a 0x0F frame is received correctly.
- Assert reset for 1 cycle during data bit 4 of a frame -> next edge: data=8'h00, we=0, busy=0; the remainder of the aborted frame produces no we; a following 0x81 frame gives data=8'h81.
- Reset held from time 0 with rx=1 -> all outputs 0; after release, no activity while rx stays high for 50 cycles.
